// File: rtl/bayes_pkg.sv
// Shared constants and stream-state encoding for the Bayes classifier datapath.
// The index generator imports the same enum so the beat order is defined once.
package bayes_pkg;

    localparam int NUM_CLASS    = 10;
    localparam int NUM_ATTR     = 784;
    localparam int SENTINEL_IDX = 800;
    localparam int TERM_W       = 16;
    localparam int ACC_W        = 26;
    localparam int CIDX_W       = 4;
    localparam int AIDX_W       = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bayes_argmax_tracker.sv
// Running argmax over per-class totals. Class 0 always seeds the best value;
// later classes replace it only on a strictly greater signed total.
module bayes_argmax_tracker
    import bayes_pkg::*;
#(
    parameter int ACC_W  = bayes_pkg::ACC_W,
    parameter int CIDX_W = bayes_pkg::CIDX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    upd_i,
    input  logic [CIDX_W-1:0]       cls_i,
    input  logic signed [ACC_W-1:0] total_i,
    output logic [CIDX_W-1:0]       best_class_o,
    output logic signed [ACC_W-1:0] best_score_o
);

    logic [CIDX_W-1:0]       best_class_q, best_class_d;
    logic signed [ACC_W-1:0] best_score_q, best_score_d;
    logic                    take;

    assign take = upd_i && ((cls_i == '0) || (total_i > best_score_q));

    always_comb begin
        best_class_d = best_class_q;
        best_score_d = best_score_q;
        if (clr_i) begin
            best_class_d = '0;
            best_score_d = '0;
        end else if (take) begin
            best_class_d = cls_i;
            best_score_d = total_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_class_q <= '0;
            best_score_q <= '0;
        end else begin
            best_class_q <= best_class_d;
            best_score_q <= best_score_d;
        end
    end

    assign best_class_o = best_class_q;
    assign best_score_o = best_score_q;

endmodule

// File: rtl/bayes_score_argmax.sv
// Sequence-checks the (class, attribute) term stream, accumulates per-class
// scores and reports the winning class once per image.
module bayes_score_argmax
    import bayes_pkg::*;
#(
    parameter int NUM_CLASS = bayes_pkg::NUM_CLASS,
    parameter int NUM_ATTR  = bayes_pkg::NUM_ATTR,
    parameter int TERM_W    = bayes_pkg::TERM_W,
    parameter int ACC_W     = bayes_pkg::ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [3:0]              in_c_idx,
    input  logic [9:0]              in_attri_idx,
    input  logic [TERM_W-1:0]       in_term,
    output logic                    busy,
    output logic                    out_valid,
    output logic [3:0]              out_class,
    output logic signed [ACC_W-1:0] out_score,
    output logic                    err
);

    localparam logic [9:0] ATTR_LIM  = 10'(NUM_ATTR);
    localparam logic [9:0] LAST_ATTR = 10'(NUM_ATTR - 1);
    localparam logic [3:0] LAST_CLS  = 4'(NUM_CLASS - 1);

    state_e                  state_q, state_d;
    logic [3:0]              exp_c_q, exp_c_d;
    logic [9:0]              exp_a_q, exp_a_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    err_q, err_d;
    logic [3:0]              out_class_q;
    logic signed [ACC_W-1:0] out_score_q;

    logic                    real_beat, match, trk_clr, trk_upd;
    logic signed [ACC_W-1:0] term_ext, sum;
    logic [3:0]              best_class;
    logic signed [ACC_W-1:0] best_score;

    assign term_ext  = {{(ACC_W-TERM_W){in_term[TERM_W-1]}}, in_term};
    assign sum       = ((exp_a_q == '0) ? '0 : acc_q) + term_ext;
    // Sentinel indices are idle slots in the generator's stream, not beats.
    assign real_beat = in_valid && (in_attri_idx < ATTR_LIM);
    assign match     = (in_c_idx == exp_c_q) && (in_attri_idx == exp_a_q);

    always_comb begin
        state_d = state_q;
        exp_c_d = exp_c_q;
        exp_a_d = exp_a_q;
        acc_d   = acc_q;
        err_d   = err_q;
        trk_clr = 1'b0;
        trk_upd = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (real_beat) begin
                    if (!match) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (exp_a_q == LAST_ATTR) begin
                        trk_upd = 1'b1;
                        acc_d   = '0;
                        exp_a_d = '0;
                        exp_c_d = exp_c_q + 4'd1;
                        if (exp_c_q == LAST_CLS)
                            state_d = ST_DONE;
                    end else begin
                        acc_d   = sum;
                        exp_a_d = exp_a_q + 10'd1;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  ;
        endcase
        // start overrides everything, including a final beat in the same cycle
        if (start) begin
            state_d = ST_ACCUM;
            exp_c_d = '0;
            exp_a_d = '0;
            acc_d   = '0;
            err_d   = 1'b0;
            trk_clr = 1'b1;
            trk_upd = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            exp_c_q     <= '0;
            exp_a_q     <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            out_class_q <= '0;
            out_score_q <= '0;
        end else begin
            state_q <= state_d;
            exp_c_q <= exp_c_d;
            exp_a_q <= exp_a_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            if (state_q == ST_DONE) begin
                out_class_q <= best_class;
                out_score_q <= best_score;
            end
        end
    end

    bayes_argmax_tracker #(
        .ACC_W  (ACC_W),
        .CIDX_W (4)
    ) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (trk_clr),
        .upd_i        (trk_upd),
        .cls_i        (exp_c_q),
        .total_i      (sum),
        .best_class_o (best_class),
        .best_score_o (best_score)
    );

    // Result is visible straight from the tracker in DONE and held afterwards.
    assign out_valid = (state_q == ST_DONE);
    assign out_class = out_valid ? best_class : out_class_q;
    assign out_score = out_valid ? best_score : out_score_q;
    assign busy      = (state_q == ST_ACCUM);
    assign err       = err_q;

endmodule

// File: doc/bayes_score_argmax.md
Name: bayes_score_argmax

Overview:
- Consumer end of the Bayes classifier index stream.
- Receives one signed log-likelihood term per (class, attribute) beat, in the order the index generator produces them: class 0..NUM_CLASS-1, attribute 0..NUM_ATTR-1 within each class.
- Accumulates a per-class score, tracks the running maximum, and emits the winning class once per image.
- Sits after the probability-table lookup and feeds the result register / CPU-visible status.

Parameters:
- NUM_CLASS, 10, number of classes (digits 0..9).
- NUM_ATTR, 784, attributes per class (28x28 pixels).
- TERM_W, 16, width of the signed per-beat log-likelihood term.
- ACC_W, 26, width of the signed accumulator. Must be >= TERM_W + ceil(log2(NUM_ATTR)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; arms the block for a new image.
- in_valid  in  1  input beat qualifier.
- in_c_idx  in  4  class index of the beat.
- in_attri_idx  in  10  attribute index of the beat; values >= NUM_ATTR are sentinel/idle.
- in_term  in  TERM_W  signed log-likelihood term for (in_c_idx, in_attri_idx).
- busy  out  1  high from start until done or error.
- out_valid  out  1  one-cycle pulse when a result is ready.
- out_class  out  4  winning class index.
- out_score  out  ACC_W  signed score of the winning class.
- err  out  1  sticky sequence error; cleared by start or rst.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - busy=0, out_valid=0, out_class=0, out_score=0, err=0.
  - Accumulator, best score, best class and expected indices all cleared.
  - Reset mid-image abandons the image; no out_valid is produced.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start -> ACCUM.
  - Expected class exp_c=0, expected attribute exp_a=0; acc=0; best_score cleared; err=0; busy=1 from the next cycle.
  - in_valid beats are ignored.
- ACCUM, sentinel beats:
  - Beats with in_attri_idx >= NUM_ATTR are ignored and are not an error.
  - in_valid=0 stalls the block with no state change. Gaps of any length are allowed.
- ACCUM, real beats:
  - A valid beat must match (exp_c, exp_a).
  - Mismatch: err=1, busy=0, -> IDLE. No out_valid.
- ACCUM, matching beat with exp_a < NUM_ATTR-1:
  - acc += sign-extended in_term (acc is replaced by the term when exp_a==0).
  - exp_a increments.
- ACCUM, matching beat with exp_a == NUM_ATTR-1:
  - Class total = acc + term.
  - If exp_c==0 or total > best_score (strict, signed), then best_score=total and best_class=exp_c. Ties keep the lower class.
  - acc=0, exp_a=0, exp_c increments.
  - If exp_c == NUM_CLASS-1 -> DONE.
- DONE (single cycle):
  - out_valid=1; out_class and out_score are driven from the best registers.
  - busy=0; -> IDLE.
  - Latency: out_valid is high exactly 1 cycle after the final beat is accepted.
- out_class and out_score hold their values until the next DONE or rst.
- start while in ACCUM restarts the image. The current beat is discarded and err is cleared.
- start in the same cycle as the final beat: start wins, and no out_valid is produced.
- Arithmetic:
  - All additions are signed, in ACC_W bits, with no saturation. ACC_W sizing guarantees no overflow.
  - The comparison is signed.

Decomposition:
- Shared package bayes_pkg:
  - NUM_CLASS, NUM_ATTR, the sentinel index constant (800), TERM_W and ACC_W.
  - State enum typedef, shared with the index generator so the stream order stays defined in one place.
- One natural sub-module: bayes_argmax_tracker (compare/update of best_score/best_class on a class-done strobe). The sequence checker and accumulator stay in the top.

Test Plan:
- Full image, class k's terms all =k (k=0..9), no gaps: out_valid exactly 1 cycle after beat (9,783); out_class=9, out_score=9*784=7056.
- All terms =-1 except class 3 attr 0 term=+5: out_class=3, out_score=-783+5=-778. Equal totals for classes 1 and 7 only: out_class=1 (tie to lower).
- Random in_valid gaps plus sentinel beats (attri=800) interleaved: result identical to the gap-free run, err=0.
- Skipped beat (class 2 attr 10 missing): err=1, busy=0, no out_valid; next start clears err and a clean image completes correctly.
- rst asserted at class 5 attr 400: all outputs 0 on the next cycle, no out_valid. start mid-image re-arms: a fresh full image yields the correct class.
- Extreme terms: all terms =-32768 (TERM_W=16): score=-25690112, no overflow, out_class=0.
